window_generator: RTL
=====================

WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter IMG_W, default 8, ifmap width in pixels (min 3).
REQ-002 Parameter IMG_H, default 8, ifmap height in pixels (min 3).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin one frame.
REQ-006 filter_valid  input  1  filter_in holds a valid 3x3 filter.
REQ-007 filter_in  input  72  nine 8-bit filter weights.
REQ-008 filter_ready  output  1  high while waiting for a filter.
REQ-009 pix_valid  input  1  pix_in holds a valid pixel.
REQ-010 pix_in  input  8  ifmap pixel, raster order, row 0 first.
REQ-011 pix_ready  output  1  high while pixels are accepted.
REQ-012 win_valid  output  1  ifmap_out/filter_out/state valid this cycle.
REQ-013 ifmap_out  output  72  3x3 sliding window.
REQ-014 filter_out  output  72  latched filter.
REQ-015 state  output  1  1 = load (first window of frame), 0 = shift.
REQ-016 busy  output  1  high from start acceptance until done.
REQ-017 done  output  1  single-cycle pulse at frame end.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_FILTER, STREAM, DONE.
REQ-019 IDLE: start=1 -> LOAD_FILTER; start in any other state SHALL be ignored.
REQ-020 LOAD_FILTER: filter_ready=1; on filter_valid=1 latch filter_in into filter_out register, -> STREAM.
REQ-021 STREAM: pix_ready=1; a pixel is accepted when pix_valid&&pix_ready; no acceptance -> counters and buffers hold.
REQ-022 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance per accepted pixel; col wraps to 0 and row increments at col=IMG_W-1.
REQ-023 Two line buffers of depth IMG_W SHALL hold the previous two rows; a 3x3 shift-register window SHALL shift one column per accepted pixel.
REQ-024 Window element (r,c), r=0 top/oldest row, c=0 leftmost/oldest column, SHALL occupy ifmap_out[8*(3r+c)+7 : 8*(3r+c)].
REQ-025 When the accepted pixel has row>=2 and col>=2, win_valid SHALL be 1 on the next cycle (latency 1) with that pixel at element (2,2); otherwise win_valid=0.
REQ-026 Windows SHALL never span a row wrap; stale buffer contents SHALL never produce win_valid=1.
REQ-027 state SHALL be 1 with the first valid window of a frame and 0 on all later windows of that frame.
REQ-028 Exactly (IMG_W-2)*(IMG_H-2) windows SHALL be emitted per frame.
REQ-029 After accepting pixel (IMG_H-1, IMG_W-1), -> DONE; pix_ready drops the following cycle.
REQ-030 DONE: done=1 for one cycle, -> IDLE; busy=0 in IDLE only.
REQ-031 ifmap_out and filter_out SHALL hold last values when win_valid=0.
REQ-032 No downstream backpressure exists; consumer SHALL take every win_valid cycle.

Reset
REQ-033 On rst: FSM -> IDLE; row, col, window registers, ifmap_out, filter_out -> 0; win_valid, state, filter_ready, pix_ready, busy, done -> 0.
REQ-034 rst mid-frame SHALL abort the frame immediately; no done pulse; next frame requires a new start and new filter.
REQ-035 Line buffer RAM need not be reset.

Verification
REQ-036 IMG_W=4, IMG_H=4, filter 0x090807060504030201, pixels 1..16 gapless -> 4 windows; first ifmap_out bytes (e0..e8) = 1,2,3,5,6,7,9,10,11 with state=1, then 2,3,4,6,7,8,10,11,12 state=0; filter_out = filter; done 1 cycle after last window.
REQ-037 Same frame, pix_valid toggled 1/0 each cycle -> identical window values/order, windows spaced by stalls, state=1 only on first.
REQ-038 start asserted in STREAM -> ignored, window count stays 4, single done pulse.
REQ-039 filter_valid delayed 5 cycles -> filter_ready high 5 cycles, pix_ready=0 until filter latched, no pixel consumed.
REQ-040 rst asserted after 7th pixel -> all outputs 0 same cycle; new start + filter + 16 pixels -> 4 correct windows, first with state=1.
REQ-041 Two back-to-back frames (pixels 1..16 then 17..32) -> each frame 4 windows, state=1 on first of each, no window mixes frames.

Source files
------------

// File: rtl/window_generator_if.sv
// Handshake/bus bundle between the window generator and its frame source / window consumer.
interface window_generator_if;
    logic        start;
    logic        filter_valid;
    logic [71:0] filter_in;
    logic        filter_ready;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic        pix_ready;
    logic        win_valid;
    logic [71:0] ifmap_out;
    logic [71:0] filter_out;
    logic        state;
    logic        busy;
    logic        done;

    modport master (
        output start, filter_valid, filter_in, pix_valid, pix_in,
        input  filter_ready, pix_ready, win_valid, ifmap_out, filter_out, state, busy, done
    );

    modport slave (
        input  start, filter_valid, filter_in, pix_valid, pix_in,
        output filter_ready, pix_ready, win_valid, ifmap_out, filter_out, state, busy, done
    );
endinterface

// File: rtl/window_generator.sv
// 3x3 sliding-window generator: latches a filter, then streams a raster ifmap through
// two line buffers and a 3x3 shift window, emitting one window per interior pixel.
module window_generator #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input logic               clk,
    input logic               rst,
    window_generator_if.slave bus
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_FILTER,
        S_STREAM,
        S_DONE
    } fsm_e;

    fsm_e          fsm_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [71:0]   win_q;
    logic [71:0]   win_d;
    logic [71:0]   ifmap_out_q;
    logic [71:0]   filter_out_q;
    logic          win_valid_q;
    logic          state_q;
    logic          first_q;
    logic          filter_ready_q;
    logic          pix_ready_q;
    logic          busy_q;
    logic          done_q;

    logic [7:0]    lb_top_q [IMG_W];
    logic [7:0]    lb_mid_q [IMG_W];

    logic          accept_c;
    logic [7:0]    top_c;
    logic [7:0]    mid_c;

    assign accept_c = (fsm_q == S_STREAM) && pix_ready_q && bus.pix_valid;
    assign top_c    = lb_top_q[col_q];
    assign mid_c    = lb_mid_q[col_q];

    // Next window: drop the oldest column, append {row-2, row-1, incoming} on the right.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[8*(3*r+0) +: 8] = win_q[8*(3*r+1) +: 8];
            win_d[8*(3*r+1) +: 8] = win_q[8*(3*r+2) +: 8];
        end
        win_d[8*2 +: 8] = top_c;
        win_d[8*5 +: 8] = mid_c;
        win_d[8*8 +: 8] = bus.pix_in;
    end

    // Line buffers carry the two previous rows; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb_top_q[col_q] <= mid_c;
            lb_mid_q[col_q] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q          <= S_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            ifmap_out_q    <= '0;
            filter_out_q   <= '0;
            win_valid_q    <= 1'b0;
            state_q        <= 1'b0;
            first_q        <= 1'b0;
            filter_ready_q <= 1'b0;
            pix_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            state_q     <= 1'b0;
            done_q      <= 1'b0;
            unique case (fsm_q)
                S_IDLE: begin
                    if (bus.start) begin
                        fsm_q          <= S_LOAD_FILTER;
                        filter_ready_q <= 1'b1;
                        busy_q         <= 1'b1;
                        col_q          <= '0;
                        row_q          <= '0;
                    end
                end
                S_LOAD_FILTER: begin
                    if (bus.filter_valid) begin
                        fsm_q          <= S_STREAM;
                        filter_out_q   <= bus.filter_in;
                        filter_ready_q <= 1'b0;
                        pix_ready_q    <= 1'b1;
                        first_q        <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (accept_c) begin
                        win_q <= win_d;
                        // Columns 0/1 of a row flush the previous row out of the window.
                        if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                            win_valid_q <= 1'b1;
                            ifmap_out_q <= win_d;
                            state_q     <= first_q;
                            first_q     <= 1'b0;
                        end
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                            if (row_q == ROW_LAST) begin
                                fsm_q       <= S_DONE;
                                pix_ready_q <= 1'b0;
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    fsm_q  <= S_IDLE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign bus.filter_ready = filter_ready_q;
    assign bus.pix_ready    = pix_ready_q;
    assign bus.win_valid    = win_valid_q;
    assign bus.ifmap_out    = ifmap_out_q;
    assign bus.filter_out   = filter_out_q;
    assign bus.state        = state_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule
